// File: rtl/packet_reader.sv
// Drains the spike-packet memory onto a valid/ready stream, one stored byte per handshake.
// A host write (write_mode) during a sweep kills it immediately so reads never overlap writes.
module packet_reader #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW:0]   count,
   input  logic          write_mode,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_data,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic          abort
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_SEND,
      S_DONE
   } state_t;

   localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LP_ONE_C = (AW+1)'(1);
   localparam logic [AW-1:0] LP_ONE_A = AW'(1);

   state_t        r_state;
   logic [AW:0]   r_cnt;
   logic [AW-1:0] r_idx;
   logic [AW-1:0] r_memAddr;
   logic [DW-1:0] r_outData;
   logic          r_outValid;
   logic          r_outLast;
   logic          r_done;
   logic          r_abort;

   logic [AW:0]   w_cntClamped;
   logic          w_isLast;

   assign w_cntClamped = (count > LP_DEPTH) ? LP_DEPTH : count;
   assign w_isLast     = ({1'b0, r_idx} == (r_cnt - LP_ONE_C));

   // done/abort are single-cycle pulses; every path that wants one re-asserts it explicitly
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_memAddr  <= '0;
         r_outData  <= '0;
         r_outValid <= 1'b0;
         r_outLast  <= 1'b0;
         r_done     <= 1'b0;
         r_abort    <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_abort <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && !write_mode) begin
                  r_cnt     <= w_cntClamped;
                  r_idx     <= '0;
                  r_memAddr <= '0;
                  if (w_cntClamped == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (write_mode) begin
                  r_state    <= S_IDLE;
                  r_outValid <= 1'b0;
                  r_outLast  <= 1'b0;
                  r_abort    <= 1'b1;
               end else begin
                  r_outData  <= mem_data;
                  r_outValid <= 1'b1;
                  r_outLast  <= w_isLast;
                  r_state    <= S_SEND;
               end
            end
            // A host write outranks a handshake landing in the same cycle
            S_SEND: begin
               if (write_mode) begin
                  r_state    <= S_IDLE;
                  r_outValid <= 1'b0;
                  r_outLast  <= 1'b0;
                  r_abort    <= 1'b1;
               end else if (out_ready) begin
                  r_outValid <= 1'b0;
                  r_outLast  <= 1'b0;
                  if (r_outLast) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx     <= r_idx + LP_ONE_A;
                     r_memAddr <= r_memAddr + LP_ONE_A;
                     r_state   <= S_FETCH;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_addr  = r_memAddr;
   assign out_data  = r_outData;
   assign out_valid = r_outValid;
   assign out_last  = r_outLast;
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign abort     = r_abort;

endmodule

// File: tb/tb_packet_reader.sv
// Directed bench for packet_reader: the bench owns the memory array and drives
// fixed sequences whose expected outputs are worked out cycle by cycle.
module tb_packet_reader;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [4:0] count;
   logic       write_mode;
   logic [3:0] mem_addr;
   logic [7:0] mem_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       busy;
   logic       done;
   logic       abort;

   logic [7:0] mem [16];

   int nCompared   = 0;
   int nMismatched = 0;

   assign mem_data = mem[mem_addr];

   packet_reader #(.DEPTH(16), .AW(4), .DW(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .count      (count),
      .write_mode (write_mode),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done),
      .abort      (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic [4:0] c, input logic w, input logic r);
      start      = s;
      count      = c;
      write_mode = w;
      out_ready  = r;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_busy"},  32'(busy), 0);
      checkOutput({tag, "_valid"}, 32'(out_valid), 0);
      checkOutput({tag, "_last"},  32'(out_last), 0);
      checkOutput({tag, "_done"},  32'(done), 0);
      checkOutput({tag, "_abort"}, 32'(abort), 0);
   endtask

   // One packet with out_ready high: FETCH edge then handshake edge
   task automatic getPacket(input int k, input int n, input string tag);
      tick();
      checkOutput($sformatf("%s_valid%0d", tag, k), 32'(out_valid), 1);
      checkOutput($sformatf("%s_data%0d", tag, k), 32'(out_data), 32'(mem[k]));
      checkOutput($sformatf("%s_last%0d", tag, k), 32'(out_last), (k == n-1) ? 1 : 0);
      tick();
      checkOutput($sformatf("%s_drop%0d", tag, k), 32'(out_valid), 0);
      checkOutput($sformatf("%s_done%0d", tag, k), 32'(done), (k == n-1) ? 1 : 0);
   endtask

   // Full sweep with out_ready high; pulseAt >= 0 fires a stray start during that packet
   task automatic runSweep(input logic [4:0] c, input int n, input int pulseAt, input string tag);
      applyStimulus(1, c, 0, 1);
      tick();
      applyStimulus(0, c, 0, 1);
      checkOutput({tag, "_busyUp"}, 32'(busy), 1);
      checkOutput({tag, "_noValid"}, 32'(out_valid), 0);
      checkOutput({tag, "_doneEarly"}, 32'(done), (n == 0) ? 1 : 0);
      for (int k = 0; k < n; k++) begin
         if (k == pulseAt) applyStimulus(1, 5'd1, 0, 1);
         getPacket(k, n, tag);
         applyStimulus(0, c, 0, 1);
      end
      if (n > 0) checkOutput({tag, "_addrEnd"}, 32'(mem_addr), 32'(n-1));
      tick();
      checkIdleZero({tag, "_after"});
      tick();
      checkIdleZero({tag, "_after2"});
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0);
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      tick();
      tick();
      checkIdleZero("reset");
      checkOutput("reset_addr", 32'(mem_addr), 0);
      checkOutput("reset_data", 32'(out_data), 0);

      rst_n = 1'b1;
      write_mode = 1'b1;
      for (int i = 0; i < 16; i++) begin
         mem[i] = 8'h10 + 8'(i);
         tick();
         checkOutput($sformatf("write_busy%0d", i), 32'(busy), 0);
      end
      write_mode = 1'b0;

      $display("[TB] full sweep of 16");
      runSweep(5'd16, 16, -1, "full");

      $display("[TB] backpressure count=3");
      applyStimulus(1, 5'd3, 0, 0);
      tick();
      applyStimulus(0, 5'd3, 0, 0);
      for (int k = 0; k < 3; k++) begin
         logic [7:0] saved;
         tick();
         saved = mem[k];
         for (int h = 0; h < 3; h++) begin
            checkOutput($sformatf("bp_valid%0d_%0d", k, h), 32'(out_valid), 1);
            checkOutput($sformatf("bp_data%0d_%0d", k, h), 32'(out_data), 32'(8'h10 + 8'(k)));
            checkOutput($sformatf("bp_last%0d_%0d", k, h), 32'(out_last), (k == 2) ? 1 : 0);
            if (h == 1) mem[k] = 8'hEE;
            out_ready = (h == 2);
            tick();
         end
         mem[k] = saved;
         out_ready = 1'b0;
         checkOutput($sformatf("bp_drop%0d", k), 32'(out_valid), 0);
         checkOutput($sformatf("bp_done%0d", k), 32'(done), (k == 2) ? 1 : 0);
      end
      tick();
      checkIdleZero("bp_after");

      $display("[TB] edge counts");
      runSweep(5'd0, 0, -1, "zero");
      runSweep(5'd20, 16, -1, "clamp");

      applyStimulus(1, 5'd5, 1, 0);
      tick();
      checkIdleZero("wmStart1");
      tick();
      checkIdleZero("wmStart2");
      applyStimulus(0, 5'd5, 0, 0);

      $display("[TB] abort on third packet");
      applyStimulus(1, 5'd5, 0, 1);
      tick();
      applyStimulus(0, 5'd5, 0, 1);
      getPacket(0, 5, "ab");
      getPacket(1, 5, "ab");
      tick();
      checkOutput("ab_valid2", 32'(out_valid), 1);
      checkOutput("ab_data2", 32'(out_data), 32'h12);
      applyStimulus(0, 5'd5, 1, 1);
      tick();
      checkOutput("ab_pulse", 32'(abort), 1);
      checkOutput("ab_valid", 32'(out_valid), 0);
      checkOutput("ab_last", 32'(out_last), 0);
      checkOutput("ab_done", 32'(done), 0);
      checkOutput("ab_busy", 32'(busy), 0);
      applyStimulus(0, 5'd5, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkIdleZero($sformatf("ab_quiet%0d", i));
      end

      $display("[TB] reset mid-sweep");
      applyStimulus(1, 5'd4, 0, 0);
      tick();
      applyStimulus(0, 5'd4, 0, 0);
      tick();
      checkOutput("rs_valid", 32'(out_valid), 1);
      rst_n = 1'b0;
      tick();
      checkIdleZero("rs");
      checkOutput("rs_addr", 32'(mem_addr), 0);
      checkOutput("rs_data", 32'(out_data), 0);
      rst_n = 1'b1;
      runSweep(5'd2, 2, -1, "postRst");

      $display("[TB] ignored start mid-sweep");
      runSweep(5'd4, 4, 1, "ign");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/packet_reader.md
# packet_reader

Sequential reader that drains the 16×8 spike-packet memory toward the SNN core. On a start command it walks the memory address from 0 upward and presents each stored byte on a valid/ready stream, one packet per handshake. It is the consuming end of the memory's write port: the host writes packets through `ui_in`, and this block reads them back out through the memory's address and read-data port. It also stops cleanly if the host resumes writing.

## Interface
Parameters:
- `DEPTH`, 16, number of memory entries.
- `AW`, 4, memory address width; `2**AW == DEPTH`.
- `DW`, 8, packet width.

Ports:
- `clk`, in, 1, single clock; all state updates on its rising edge.
- `rst_n`, in, 1, reset, synchronous and active-low.
- `start`, in, 1, request to begin a read sweep; sampled in IDLE only.
- `count`, in, AW+1, number of packets to read; latched on an accepted start.
- `write_mode`, in, 1, host write-enable of the memory; a read sweep must never overlap it.
- `mem_addr`, out, AW, address driven to the memory.
- `mem_data`, in, DW, memory read data; combinational function of `mem_addr`.
- `out_data`, out, DW, registered packet to the core.
- `out_valid`, out, 1, `out_data` is valid.
- `out_ready`, in, 1, the core accepts `out_data`.
- `out_last`, out, 1, qualifies the final packet of the sweep; meaningful only with `out_valid`.
- `busy`, out, 1, high in any state other than IDLE.
- `done`, out, 1, one-cycle pulse after the last packet handshake.
- `abort`, out, 1, one-cycle pulse when a sweep is killed by `write_mode`.

## Operation
- State machine states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - A start is accepted when `start`=1 and `write_mode`=0. `start` with `write_mode`=1 is ignored.
  - On acceptance: latch `cnt = min(count, DEPTH)` and clear `idx` and `mem_addr` to 0.
  - If `cnt`=0, go to DONE. Otherwise go to FETCH.
- FETCH: register `out_data <= mem_data`, set `out_valid`=1, and set `out_last = (idx == cnt-1)`. Go to SEND.
- SEND:
  - `out_data`, `out_valid` and `out_last` hold stable until `out_valid && out_ready`.
  - On that handshake, clear `out_valid`.
  - If this was the last packet, go to DONE.
  - Otherwise increment `idx` and `mem_addr` and go to FETCH.
- DONE: `done`=1 for exactly this cycle, then return to IDLE.
- Abort: `write_mode`=1 in FETCH or SEND returns the block to IDLE on the next edge.
  - `out_valid` and `out_last` go to 0 and no further handshake occurs.
  - `abort`=1 for one cycle; `done` is not asserted.
  - Abort has priority over a simultaneous `out_ready` handshake.
- `start` while `busy`=1 is ignored and not queued.
- `mem_addr` never exceeds `cnt-1`; no wrap-around within a sweep. `mem_addr` holds its value in IDLE until the next accepted start.
- `count` > DEPTH is clamped to DEPTH; for example `count`=20 reads 16 packets.
- `count` and `mem_data` changes after acceptance do not affect the latched `cnt`. A packet already captured in `out_data` does not change.

## Timing
- Reset values: every output is 0, including `mem_addr`, `out_data`, `out_valid`, `out_last`, `busy`, `done` and `abort`. The state is IDLE.
- Reset mid-sweep returns all of the above to the reset values on that edge. No `done` or `abort` is produced.
- Start latency: start accepted at edge E0 (FETCH from E0); `out_valid`=1 after edge E1.
- Packet spacing: with `out_ready` held at 1, one packet every 2 cycles.
- Sweep length with `out_ready` held at 1: `count`=N needs 2N+1 cycles from acceptance to the `done` cycle.
- `count`=0: `done` is high in the cycle after acceptance; `out_valid` never rises.
- `busy` rises in the cycle after acceptance and falls in the cycle after `done` or `abort`.

## Test plan
- Reset then write: reset, then write mem[i] = 0x10+i for i = 0..15 with `write_mode`. Then `start` with `count`=16 and `out_ready`=1 → 16 packets 0x10..0x1F in order, `out_last` only on 0x1F, `done` pulse 33 cycles after acceptance, `mem_addr` ends at 15.
- Backpressure: `count`=3 with `out_ready` toggled 0,0,1 per packet → each packet is held stable for 3 cycles and packet order is unchanged.
- Edge counts: `count`=0 → `done` next cycle and no `out_valid`. `count`=20 → exactly 16 packets. `start` while `write_mode`=1 → stays IDLE with `busy`=0.
- Abort: assert `write_mode` while the 3rd packet is valid, with `out_ready`=1 in the same cycle → `abort` pulse, no 3rd handshake, no `done`, `out_valid`=0 next cycle.
- Reset mid-sweep: drop `rst_n` during SEND → all outputs 0 on the next edge. A following start with `count`=2 reads mem[0] and mem[1] correctly.
- Ignored start: pulse `start` during a sweep → no restart, `idx` continues, exactly one `done`.
